// File: rtl/mvu_job_dispatcher.sv
// mvu_job_dispatcher
//   Queues MVU job descriptors from the host/pito control path and dispatches
//   them strictly in order to their target MVU over the per-MVU
//   prec/baddr/iword/start configuration bundle. A job is launched only when
//   its target MVU is neither busy nor still marked in flight. The head job
//   blocks all later jobs until it has been handed off.
//
//   Optional feature (macro MVU_DISPATCH_TIMEOUT_EN): bounds the wait for the
//   MVU busy acknowledge to ACK_TO cycles. On expiry the sticky err_timeout is
//   set, the in-flight mark is dropped and the job is popped. Without the
//   macro, ACK waits indefinitely and err_timeout is tied low.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   job_valid / job_ready     host job handshake (ready = FIFO not full)
//   job_mvu/prec/baddr/iword  job descriptor
//   mvu_data_prec/baddr/iword per-MVU configuration slices (slice i = [W*i +: W])
//   mvu_data_start            one-cycle start pulse per MVU
//   mvu_data_busy             MVU busy inputs
//   mvu_irq_tap               MVU job-done pulses
//   inflight                  MVU has a dispatched, unfinished job
//   q_count                   number of queued jobs
//   err_timeout               sticky busy-acknowledge timeout flag
module mvu_job_dispatcher #(
   parameter int NMVU   = 8,
   parameter int XLEN   = 32,
   parameter int QDEPTH = 4,
   parameter int ACK_TO = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    job_valid,
   output logic                    job_ready,
   input  logic [$clog2(NMVU)-1:0] job_mvu,
   input  logic [31:0]             job_prec,
   input  logic [31:0]             job_baddr,
   input  logic [XLEN-1:0]         job_iword,
   output logic [NMVU*32-1:0]      mvu_data_prec,
   output logic [NMVU*32-1:0]      mvu_data_baddr,
   output logic [NMVU*XLEN-1:0]    mvu_data_iword,
   output logic [NMVU-1:0]         mvu_data_start,
   input  logic [NMVU-1:0]         mvu_data_busy,
   input  logic [NMVU-1:0]         mvu_irq_tap,
   output logic [NMVU-1:0]         inflight,
   output logic [$clog2(QDEPTH):0] q_count,
   output logic                    err_timeout
);

   localparam int MW = $clog2(NMVU);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      START = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t state_r;
   state_t state_nxt_s;

   logic [MW-1:0]   fifo_mvu_r   [QDEPTH];
   logic [31:0]     fifo_prec_r  [QDEPTH];
   logic [31:0]     fifo_baddr_r [QDEPTH];
   logic [XLEN-1:0] fifo_iword_r [QDEPTH];

   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic          ready_r;

   logic [MW-1:0]   head_mvu_s;
   logic [31:0]     head_prec_s;
   logic [31:0]     head_baddr_s;
   logic [XLEN-1:0] head_iword_s;

   logic empty_s;
   logic full_s;
   logic push_s;
   logic pop_s;
   logic tgt_ok_s;
   logic tgt_free_s;
   logic load_s;
   logic timeout_s;

   logic [NMVU-1:0] onehot_s;
   logic [NMVU-1:0] set_mask_s;
   logic [NMVU-1:0] clr_mask_s;
   logic [NMVU-1:0] inflight_r;
   logic [NMVU-1:0] start_r;

   logic [NMVU*32-1:0]   prec_r;
   logic [NMVU*32-1:0]   baddr_r;
   logic [NMVU*XLEN-1:0] iword_r;

   assign head_mvu_s   = fifo_mvu_r[rd_ptr_r];
   assign head_prec_s  = fifo_prec_r[rd_ptr_r];
   assign head_baddr_s = fifo_baddr_r[rd_ptr_r];
   assign head_iword_s = fifo_iword_r[rd_ptr_r];

   assign empty_s = (count_r == {CW{1'b0}});
   assign full_s  = (count_r == FULL_CNT);
   assign push_s  = job_valid && !full_s;

   // An id field wider than needed can name a non-existent MVU.
   assign tgt_ok_s   = (32'(head_mvu_s) < 32'(NMVU));
   assign tgt_free_s = tgt_ok_s && !mvu_data_busy[head_mvu_s] && !inflight_r[head_mvu_s];
   assign onehot_s   = tgt_ok_s ? ({{(NMVU-1){1'b0}}, 1'b1} << head_mvu_s) : {NMVU{1'b0}};

`ifdef MVU_DISPATCH_TIMEOUT_EN
   localparam int AW = $clog2(ACK_TO + 1);
   logic [AW-1:0] ack_cnt_r;
   logic          ack_to_hit_s;
   logic          err_r;

   // ACK dwell counter; zero on every ACK entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_cnt_r <= {AW{1'b0}};
      end else if (state_r == ACK) begin
         ack_cnt_r <= ack_cnt_r + AW'(1);
      end else begin
         ack_cnt_r <= {AW{1'b0}};
      end
   end

   // Counter value during the ACK_TO-th ACK cycle.
   assign ack_to_hit_s = (ack_cnt_r == AW'(ACK_TO - 1));

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (timeout_s) begin
         err_r <= 1'b1;
      end
   end

   assign err_timeout = err_r;
`else
   assign err_timeout = 1'b0;
`endif

   // Dispatch FSM next-state and control decode.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               if (!tgt_ok_s) begin
                  // Unroutable head: discard it without driving anything.
                  pop_s = 1'b1;
               end else if (tgt_free_s) begin
                  state_nxt_s = LOAD;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD: begin
            state_nxt_s = START;
         end
         START: begin
            state_nxt_s = ACK;
         end
         ACK: begin
            if (mvu_data_busy[head_mvu_s]) begin
               pop_s       = 1'b1;
               state_nxt_s = IDLE;
            end
`ifdef MVU_DISPATCH_TIMEOUT_EN
            else if (ack_to_hit_s) begin
               timeout_s   = 1'b1;
               pop_s       = 1'b1;
               state_nxt_s = IDLE;
            end
`endif
            else begin
               state_nxt_s = ACK;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Derived strobes and FIFO occupancy update.
   always_comb begin
      load_s      = (state_r == IDLE) && (state_nxt_s == LOAD);
      set_mask_s  = (state_r == START) ? onehot_s : {NMVU{1'b0}};
      clr_mask_s  = mvu_irq_tap | (timeout_s ? onehot_s : {NMVU{1'b0}});
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Job FIFO storage, pointers and occupancy; pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         ready_r  <= 1'b1;
         for (int i = 0; i < QDEPTH; i++) begin
            fifo_mvu_r[i]   <= {MW{1'b0}};
            fifo_prec_r[i]  <= 32'h0000_0000;
            fifo_baddr_r[i] <= 32'h0000_0000;
            fifo_iword_r[i] <= {XLEN{1'b0}};
         end
      end else begin
         if (push_s) begin
            fifo_mvu_r[wr_ptr_r]   <= job_mvu;
            fifo_prec_r[wr_ptr_r]  <= job_prec;
            fifo_baddr_r[wr_ptr_r] <= job_baddr;
            fifo_iword_r[wr_ptr_r] <= job_iword;
            wr_ptr_r               <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r <= count_nxt_s;
         ready_r <= (count_nxt_s != FULL_CNT);
      end
   end

   // Per-MVU configuration slices, loaded on the edge that enters LOAD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prec_r  <= {(NMVU*32){1'b0}};
         baddr_r <= {(NMVU*32){1'b0}};
         iword_r <= {(NMVU*XLEN){1'b0}};
      end else begin
         for (int i = 0; i < NMVU; i++) begin
            if (load_s && onehot_s[i]) begin
               prec_r[32*i +: 32]     <= head_prec_s;
               baddr_r[32*i +: 32]    <= head_baddr_s;
               iword_r[XLEN*i +: XLEN] <= head_iword_s;
            end
         end
      end
   end

   // Start pulse: high for exactly the START cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_r <= {NMVU{1'b0}};
      end else if (state_r == LOAD) begin
         start_r <= onehot_s;
      end else begin
         start_r <= {NMVU{1'b0}};
      end
   end

   // In-flight tracking. A set never collides with a real clear of the same
   // MVU because dispatch needs inflight=0, so a stray irq on an idle MVU
   // is harmlessly overridden by the set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_r <= {NMVU{1'b0}};
      end else begin
         inflight_r <= (inflight_r & ~clr_mask_s) | set_mask_s;
      end
   end

   assign job_ready      = ready_r;
   assign q_count        = count_r;
   assign inflight       = inflight_r;
   assign mvu_data_start = start_r;
   assign mvu_data_prec  = prec_r;
   assign mvu_data_baddr = baddr_r;
   assign mvu_data_iword = iword_r;

endmodule

// File: tb/tb_mvu_job_dispatcher.sv
// Self-checking bench for mvu_job_dispatcher. A behavioural MVU responder
// raises busy on start, holds it a random number of cycles, then pulses
// irq_tap. Expected behaviour is modelled as an in-order job list: every
// accepted job must be started exactly once, in acceptance order, with its
// own descriptor on its target's slice.
module tb_mvu_job_dispatcher;

   localparam int NMVU   = 8;
   localparam int XLEN   = 32;
   localparam int QDEPTH = 4;
   localparam int ACK_TO = 16;

   logic                 clk;
   logic                 rst_n;
   logic                 job_valid;
   logic                 job_ready;
   logic [2:0]           job_mvu;
   logic [31:0]          job_prec;
   logic [31:0]          job_baddr;
   logic [XLEN-1:0]      job_iword;
   logic [NMVU*32-1:0]   mvu_data_prec;
   logic [NMVU*32-1:0]   mvu_data_baddr;
   logic [NMVU*XLEN-1:0] mvu_data_iword;
   logic [NMVU-1:0]      mvu_data_start;
   logic [NMVU-1:0]      mvu_data_busy;
   logic [NMVU-1:0]      mvu_irq_tap;
   logic [NMVU-1:0]      inflight;
   logic [2:0]           q_count;
   logic                 err_timeout;

   logic [NMVU-1:0] busy_man;
   logic [NMVU-1:0] irq_man;
   logic [NMVU-1:0] resp_busy;
   logic [NMVU-1:0] resp_irq;
   logic [NMVU-1:0] resp_act;
   logic            resp_en;
   int              rem [NMVU];
   int              viol;

   int total;
   int bad;

   typedef struct {
      logic [7:0]  vec;
      logic [31:0] prec;
      logic [31:0] baddr;
      logic [31:0] iword;
   } rec_t;

   typedef struct {
      int          mvu;
      logic [31:0] prec;
      logic [31:0] baddr;
      logic [31:0] iword;
   } job_t;

   rec_t start_log[$];
   job_t exp_q[$];

   assign mvu_data_busy = busy_man | resp_busy;
   assign mvu_irq_tap   = irq_man | resp_irq;

   mvu_job_dispatcher #(
      .NMVU(NMVU), .XLEN(XLEN), .QDEPTH(QDEPTH), .ACK_TO(ACK_TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_mvu(job_mvu), .job_prec(job_prec), .job_baddr(job_baddr), .job_iword(job_iword),
      .mvu_data_prec(mvu_data_prec), .mvu_data_baddr(mvu_data_baddr),
      .mvu_data_iword(mvu_data_iword), .mvu_data_start(mvu_data_start),
      .mvu_data_busy(mvu_data_busy), .mvu_irq_tap(mvu_irq_tap),
      .inflight(inflight), .q_count(q_count), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lowbit(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   // Start monitor plus behavioural MVU responder.
   always @(negedge clk) begin
      if (mvu_data_start != 8'h00) begin
         start_log.push_back('{mvu_data_start,
                               mvu_data_prec[32*lowbit(mvu_data_start) +: 32],
                               mvu_data_baddr[32*lowbit(mvu_data_start) +: 32],
                               mvu_data_iword[32*lowbit(mvu_data_start) +: 32]});
         if (resp_en && ((mvu_data_start & (resp_busy | resp_act)) != 8'h00))
            viol <= viol + 1;
      end
      for (int i = 0; i < NMVU; i++) begin
         if (!resp_en) begin
            resp_busy[i] <= 1'b0;
            resp_irq[i]  <= 1'b0;
            resp_act[i]  <= 1'b0;
         end else begin
            resp_irq[i] <= 1'b0;
            if (resp_irq[i]) resp_act[i] <= 1'b0;
            if (mvu_data_start[i]) begin
               resp_busy[i] <= 1'b1;
               resp_act[i]  <= 1'b1;
               rem[i]       <= int'($urandom_range(2, 7));
            end else if (resp_busy[i]) begin
               if (rem[i] == 1) begin
                  resp_busy[i] <= 1'b0;
                  resp_irq[i]  <= 1'b1;
               end else begin
                  rem[i] <= rem[i] - 1;
               end
            end
         end
      end
   end

   task automatic push(input int m, input logic [31:0] p, input logic [31:0] b, input logic [31:0] w);
      bit   ok;
      job_t j;
      @(negedge clk);
      job_mvu = 3'(m); job_prec = p; job_baddr = b; job_iword = w; job_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (job_ready === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      @(posedge clk);
      #1 job_valid = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL push_accept: job_ready stuck at %b, expected 1", job_ready);
      end else begin
         j.mvu = m; j.prec = p; j.baddr = b; j.iword = w;
         exp_q.push_back(j);
      end
   endtask

   task automatic wait_log(input int n, input bit need_idle, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk); #1;
         if (start_log.size() >= n &&
             (!need_idle || (q_count == 3'd0 && inflight == 8'h00 && resp_busy == 8'h00))) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      resp_en = 1'b0; busy_man = 8'h00; irq_man = 8'h00; job_valid = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      start_log.delete(); exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      total++;
      if ({mvu_data_start, inflight, q_count, err_timeout} !== 28'h0) begin
         bad++;
         $display("FAIL reset_outputs: start=%h inflight=%h q_count=%0d err=%b, expected all 0",
                  mvu_data_start, inflight, q_count, err_timeout);
      end
      total++;
      if ((mvu_data_prec | mvu_data_baddr | mvu_data_iword) !== 256'h0) begin
         bad++;
         $display("FAIL reset_slices: slices not zero during reset");
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (job_ready !== 1'b1 || q_count !== 3'd0) begin
         bad++;
         $display("FAIL reset_ready: job_ready=%b q_count=%0d, expected 1 and 0", job_ready, q_count);
      end
   endtask

   task automatic test_single_dispatch();
      push(2, 32'h0000_0202, 32'h0000_0040, 32'h0000_DEAD);
      @(negedge clk);  // after E0
      total++;
      if (q_count !== 3'd1 || mvu_data_start !== 8'h00) begin
         bad++;
         $display("FAIL single_e0: q_count=%0d start=%h, expected 1 and 00", q_count, mvu_data_start);
      end
      @(negedge clk);  // after E1
      total++;
      if (mvu_data_start !== 8'h00 || mvu_data_prec[64 +: 32] !== 32'h0202 ||
          mvu_data_baddr[64 +: 32] !== 32'h40 || mvu_data_iword[64 +: 32] !== 32'hDEAD) begin
         bad++;
         $display("FAIL single_load: start=%h prec=%h baddr=%h iword=%h, expected 00 0202 40 dead",
                  mvu_data_start, mvu_data_prec[64 +: 32], mvu_data_baddr[64 +: 32], mvu_data_iword[64 +: 32]);
      end
      @(negedge clk);  // after E2
      total++;
      if (mvu_data_start !== 8'h04) begin
         bad++;
         $display("FAIL single_start: start=%h, expected 04", mvu_data_start);
      end
      @(negedge clk);  // after E3
      total++;
      if (mvu_data_start !== 8'h00 || inflight !== 8'h04) begin
         bad++;
         $display("FAIL single_ack: start=%h inflight=%h, expected 00 and 04", mvu_data_start, inflight);
      end
      busy_man[2] = 1'b1;
      @(negedge clk);  // after E4
      total++;
      if (q_count !== 3'd0 || mvu_data_prec[0 +: 32] !== 32'h0 || mvu_data_iword[64 +: 32] !== 32'hDEAD) begin
         bad++;
         $display("FAIL single_pop: q_count=%0d slice0=%h slice2_iword=%h, expected 0 0 dead",
                  q_count, mvu_data_prec[0 +: 32], mvu_data_iword[64 +: 32]);
      end
      busy_man[2] = 1'b0;
   endtask

   task automatic test_irq_ignore();
      @(negedge clk); irq_man = 8'h01;
      @(negedge clk); irq_man = 8'h00;
      @(negedge clk);
      total++;
      if (inflight !== 8'h04 || q_count !== 3'd0 || job_ready !== 1'b1) begin
         bad++;
         $display("FAIL irq_ignore: inflight=%h q_count=%0d ready=%b, expected 04 0 1", inflight, q_count, job_ready);
      end
      irq_man = 8'h04;
      @(negedge clk); irq_man = 8'h00;
      total++;
      if (inflight !== 8'h00) begin
         bad++;
         $display("FAIL irq_clear: inflight=%h, expected 00", inflight);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset();
      busy_man = 8'hFF;
      for (int j = 0; j < 4; j++)
         push(int'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      @(negedge clk); job_mvu = 3'(5); job_prec = $urandom; job_baddr = $urandom; job_iword = $urandom;
      job_valid = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      total++;
      if (job_ready !== 1'b0 || q_count !== 3'd4 || start_log.size() != 0) begin
         bad++;
         $display("FAIL b2b_full: ready=%b q_count=%0d starts=%0d, expected 0 4 0",
                  job_ready, q_count, start_log.size());
      end
      job_valid = 1'b0;
      busy_man = 8'h00; resp_en = 1'b1;
      push(5, job_prec, job_baddr, job_iword);
      wait_log(5, 1'b1, ok);
      total++;
      if (!ok || start_log.size() != 5) begin
         bad++;
         $display("FAIL b2b_drain: starts=%0d, expected 5", start_log.size());
      end
      for (int i = 0; i < exp_q.size() && i < start_log.size(); i++) begin
         total++;
         if (start_log[i].vec !== (8'h01 << exp_q[i].mvu) || start_log[i].prec !== exp_q[i].prec ||
             start_log[i].baddr !== exp_q[i].baddr || start_log[i].iword !== exp_q[i].iword) begin
            bad++;
            $display("FAIL b2b_order[%0d]: start=%h prec=%h, expected %h %h",
                     i, start_log[i].vec, start_log[i].prec, 8'h01 << exp_q[i].mvu, exp_q[i].prec);
         end
      end
   endtask

   task automatic test_hol_block();
      bit ok;
      do_reset();
      push(3, 32'hA0, 32'hA1, 32'hA2);
      wait_log(1, 1'b0, ok);
      busy_man[3] = 1'b1;
      @(negedge clk); @(negedge clk);
      busy_man[3] = 1'b0;
      push(3, 32'hB0, 32'hB1, 32'hB2);
      push(5, 32'hC0, 32'hC1, 32'hC2);
      repeat (10) @(negedge clk);
      total++;
      if (!ok || start_log.size() != 1 || inflight !== 8'h08 || q_count !== 3'd2) begin
         bad++;
         $display("FAIL hol_block: starts=%0d inflight=%h q_count=%0d, expected 1 08 2",
                  start_log.size(), inflight, q_count);
      end
      irq_man = 8'h08;
      @(negedge clk); irq_man = 8'h00;
      total++;
      if (inflight !== 8'h00) begin
         bad++;
         $display("FAIL hol_irq: inflight=%h, expected 00", inflight);
      end
      resp_en = 1'b1;
      wait_log(3, 1'b1, ok);
      total++;
      if (!ok || start_log.size() != 3) begin
         bad++;
         $display("FAIL hol_drain: starts=%0d, expected 3", start_log.size());
      end
      for (int i = 0; i < 3 && i < start_log.size(); i++) begin
         total++;
         if (start_log[i].vec !== (8'h01 << exp_q[i].mvu) || start_log[i].prec !== exp_q[i].prec ||
             start_log[i].iword !== exp_q[i].iword) begin
            bad++;
            $display("FAIL hol_order[%0d]: start=%h prec=%h, expected %h %h",
                     i, start_log[i].vec, start_log[i].prec, 8'h01 << exp_q[i].mvu, exp_q[i].prec);
         end
      end
   endtask

   task automatic test_reset_mid_start();
      do_reset();
      push(1, 32'h11, 32'h22, 32'h33);
      @(posedge clk); @(posedge clk); #2;
      total++;
      if (mvu_data_start !== 8'h02) begin
         bad++;
         $display("FAIL rst_pre: start=%h, expected 02", mvu_data_start);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (mvu_data_start !== 8'h00 || q_count !== 3'd0) begin
         bad++;
         $display("FAIL rst_drop: start=%h q_count=%0d, expected 00 0", mvu_data_start, q_count);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (6) @(negedge clk);
      total++;
      if (q_count !== 3'd0 || inflight !== 8'h00 || job_ready !== 1'b1 || start_log.size() != 0) begin
         bad++;
         $display("FAIL rst_after: q_count=%0d inflight=%h ready=%b starts=%0d, expected 0 00 1 0",
                  q_count, inflight, job_ready, start_log.size());
      end
   endtask

   task automatic test_ack_wait();
      do_reset();
      push(6, 32'h66, 32'h67, 32'h68);
`ifdef MVU_DISPATCH_TIMEOUT_EN
      repeat (18) @(posedge clk);
      @(negedge clk);
      total++;
      if (err_timeout !== 1'b0 || q_count !== 3'd1 || inflight !== 8'h40) begin
         bad++;
         $display("FAIL to_before: err=%b q_count=%0d inflight=%h, expected 0 1 40", err_timeout, q_count, inflight);
      end
      @(negedge clk);
      total++;
      if (err_timeout !== 1'b1 || q_count !== 3'd0 || inflight !== 8'h00) begin
         bad++;
         $display("FAIL to_fire: err=%b q_count=%0d inflight=%h, expected 1 0 00", err_timeout, q_count, inflight);
      end
      repeat (5) @(negedge clk);
      total++;
      if (err_timeout !== 1'b1) begin
         bad++;
         $display("FAIL to_sticky: err=%b, expected 1", err_timeout);
      end
      do_reset();
      total++;
      if (err_timeout !== 1'b0) begin
         bad++;
         $display("FAIL to_reset: err=%b, expected 0", err_timeout);
      end
`else
      repeat (40) @(negedge clk);
      total++;
      if (err_timeout !== 1'b0 || q_count !== 3'd1 || inflight !== 8'h40) begin
         bad++;
         $display("FAIL ack_wait: err=%b q_count=%0d inflight=%h, expected 0 1 40", err_timeout, q_count, inflight);
      end
      busy_man[6] = 1'b1;
      @(negedge clk); @(negedge clk);
      total++;
      if (q_count !== 3'd0) begin
         bad++;
         $display("FAIL ack_pop: q_count=%0d, expected 0", q_count);
      end
      busy_man[6] = 1'b0; irq_man = 8'h40;
      @(negedge clk); irq_man = 8'h00;
      total++;
      if (inflight !== 8'h00) begin
         bad++;
         $display("FAIL ack_irq: inflight=%h, expected 00", inflight);
      end
`endif
   endtask

   task automatic test_random();
      bit ok;
      int v0;
      int last;
      do_reset();
      resp_en = 1'b1;
      v0 = viol;
      for (int j = 0; j < 20; j++) begin
         push(int'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_log(20, 1'b1, ok);
      total++;
      if (!ok || start_log.size() != 20) begin
         bad++;
         $display("FAIL rnd_drain: starts=%0d, expected 20", start_log.size());
      end
      total++;
      if (viol != v0) begin
         bad++;
         $display("FAIL rnd_free: %0d starts to a non-free MVU, expected 0", viol - v0);
      end
      for (int i = 0; i < exp_q.size() && i < start_log.size(); i++) begin
         total++;
         if (start_log[i].vec !== (8'h01 << exp_q[i].mvu) || start_log[i].prec !== exp_q[i].prec ||
             start_log[i].baddr !== exp_q[i].baddr || start_log[i].iword !== exp_q[i].iword) begin
            bad++;
            $display("FAIL rnd_order[%0d]: start=%h prec=%h baddr=%h, expected %h %h %h", i,
                     start_log[i].vec, start_log[i].prec, start_log[i].baddr,
                     8'h01 << exp_q[i].mvu, exp_q[i].prec, exp_q[i].baddr);
         end
      end
      for (int m = 0; m < NMVU; m++) begin
         last = -1;
         for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i].mvu == m) last = i;
         if (last >= 0) begin
            total++;
            if (mvu_data_prec[32*m +: 32] !== exp_q[last].prec || mvu_data_baddr[32*m +: 32] !== exp_q[last].baddr ||
                mvu_data_iword[32*m +: 32] !== exp_q[last].iword) begin
               bad++;
               $display("FAIL rnd_hold[%0d]: prec=%h, expected %h", m, mvu_data_prec[32*m +: 32], exp_q[last].prec);
            end
         end
      end
   endtask

   initial begin
      total = 0; bad = 0; viol = 0;
      rst_n = 1'b0; job_valid = 1'b0; job_mvu = 3'd0;
      job_prec = 32'h0; job_baddr = 32'h0; job_iword = 32'h0;
      busy_man = 8'h00; irq_man = 8'h00; resp_en = 1'b0;
      test_reset();
      test_single_dispatch();
      test_irq_ignore();
      test_back_to_back();
      test_hol_block();
      test_reset_mid_start();
      test_ack_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
